// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the MEM stage and data memory
// The stage drives the request side (master); the memory answers with ack and read data (slave).
interface mem_access_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  memReq;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWdata;
    logic [DATA_WIDTH-1:0] memRdata;
    logic                  memAck;

    modport master (
        output memReq,
        output memWe,
        output memAddr,
        output memWdata,
        input  memRdata,
        input  memAck
    );

    modport slave (
        input  memReq,
        input  memWe,
        input  memAddr,
        input  memWdata,
        output memRdata,
        output memAck
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: one req/ack data access per load/store, stalls upstream
// Optional watchdog abort of a hung access is built when MEM_TIMEOUT_EN is defined.
module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     ALUResult_in,
    input  logic                      memRead_in,
    input  logic                      memWrite_in,
    input  logic [1:0]                memToReg_in,
    input  logic [DATA_WIDTH-1:0]     registerFileDataB_in,
    input  logic [REG_ADDR_WIDTH-1:0] registerFileWrite_in,
    input  logic                      regWrite_in,
    input  logic [DATA_WIDTH-1:0]     pcpp_in,
    mem_access_stage_if.master        mem,
    output logic [DATA_WIDTH-1:0]     readData,
    output logic [DATA_WIDTH-1:0]     ALUResult,
    output logic [1:0]                memToReg,
    output logic [REG_ADDR_WIDTH-1:0] registerFileWrite,
    output logic                      regWrite,
    output logic [DATA_WIDTH-1:0]     pcpp,
    output logic                      stall,
    output logic                      memFault
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;
    logic   mem_op;
    logic   issue;
    logic   complete;
    logic   tmo_hit;

    logic                      req_q;
    logic                      we_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;

    // Pass-through fields of the instruction parked while its access is outstanding
    logic [DATA_WIDTH-1:0]     cap_alu;
    logic [1:0]                cap_m2r;
    logic [REG_ADDR_WIDTH-1:0] cap_rfw;
    logic                      cap_rw;
    logic [DATA_WIDTH-1:0]     cap_pc;

    assign mem_op       = memRead_in | memWrite_in;
    assign mem.memReq   = req_q;
    assign mem.memWe    = we_q;
    assign mem.memAddr  = addr_q;
    assign mem.memWdata = wdata_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             fault_q;

    // An ack arriving in the same cycle as the limit still wins over the abort
    assign tmo_hit  = (state_q == BUSY) && !mem.memAck && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign memFault = fault_q;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            fault_q <= 1'b0;
        end else begin
            if (issue) begin
                tmo_cnt <= '0;
            end else if (state_q == BUSY && !complete) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                fault_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign memFault = 1'b0;
`endif

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d = BUSY;
                    issue   = 1'b1;
                end
            end
            BUSY: begin
                if (mem.memAck || tmo_hit) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by reset so an aborted access releases the pipeline without waiting for an edge
    assign stall = !reset &&
                   (((state_q == IDLE) && mem_op) ||
                    ((state_q == BUSY) && !(mem.memAck || tmo_hit)));

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            req_q             <= 1'b0;
            we_q              <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= '0;
            cap_alu           <= '0;
            cap_m2r           <= '0;
            cap_rfw           <= '0;
            cap_rw            <= 1'b0;
            cap_pc            <= '0;
            readData          <= '0;
            ALUResult         <= '0;
            memToReg          <= '0;
            registerFileWrite <= '0;
            regWrite          <= 1'b0;
            pcpp              <= '0;
        end else if (state_q == IDLE) begin
            if (issue) begin
                req_q    <= 1'b1;
                we_q     <= memWrite_in;
                addr_q   <= ALUResult_in[ADDR_WIDTH-1:0];
                wdata_q  <= registerFileDataB_in;
                cap_alu  <= ALUResult_in;
                cap_m2r  <= memToReg_in;
                cap_rfw  <= registerFileWrite_in;
                cap_rw   <= regWrite_in;
                cap_pc   <= pcpp_in;
                regWrite <= 1'b0;
            end else begin
                readData          <= '0;
                ALUResult         <= ALUResult_in;
                memToReg          <= memToReg_in;
                registerFileWrite <= registerFileWrite_in;
                regWrite          <= regWrite_in;
                pcpp              <= pcpp_in;
            end
        end else begin
            if (complete) begin
                req_q             <= 1'b0;
                readData          <= (we_q || tmo_hit) ? '0 : mem.memRdata;
                ALUResult         <= cap_alu;
                memToReg          <= cap_m2r;
                registerFileWrite <= cap_rfw;
                regWrite          <= cap_rw;
                pcpp              <= cap_pc;
            end else begin
                regWrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage against a word-memory model
module tb_mem_access_stage;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] ALUResult_in, registerFileDataB_in, pcpp_in;
    logic          memRead_in, memWrite_in, regWrite_in;
    logic [1:0]    memToReg_in;
    logic [RW-1:0] registerFileWrite_in;
    logic [DW-1:0] readData, ALUResult, pcpp;
    logic [1:0]    memToReg;
    logic [RW-1:0] registerFileWrite;
    logic          regWrite, stall, memFault;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem_model [0:7];

    mem_access_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_access_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .TIMEOUT_CYCLES(15)) dut (
        .clock(clock), .reset(reset),
        .ALUResult_in(ALUResult_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .memToReg_in(memToReg_in), .registerFileDataB_in(registerFileDataB_in),
        .registerFileWrite_in(registerFileWrite_in), .regWrite_in(regWrite_in), .pcpp_in(pcpp_in),
        .mem(bus.master),
        .readData(readData), .ALUResult(ALUResult), .memToReg(memToReg),
        .registerFileWrite(registerFileWrite), .regWrite(regWrite), .pcpp(pcpp),
        .stall(stall), .memFault(memFault)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

    task automatic idle_inputs();
        ALUResult_in = '0; registerFileDataB_in = '0; pcpp_in = '0;
        memRead_in = 1'b0; memWrite_in = 1'b0; regWrite_in = 1'b0;
        memToReg_in = '0; registerFileWrite_in = '0;
        bus.memAck = 1'b0; bus.memRdata = '0;
    endtask

    task automatic rand_inputs();
        ALUResult_in = $urandom; registerFileDataB_in = $urandom; pcpp_in = $urandom;
        memRead_in = 1'($urandom); memWrite_in = 1'($urandom); regWrite_in = 1'($urandom);
        memToReg_in = 2'($urandom); registerFileWrite_in = RW'($urandom);
    endtask

    // Drive one instruction from IDLE (called at negedge+1) and check it until it retires.
    task automatic do_instr(input string tag, input logic [DW-1:0] alu, input logic rd, input logic wr,
                            input logic [1:0] m2r, input logic [DW-1:0] db, input logic [RW-1:0] rfw,
                            input logic rw, input logic [DW-1:0] pc, input int delay);
        logic          is_mem;
        logic [DW-1:0] exp_rd;
        int            idx;
        is_mem = rd | wr;
        idx = int'(alu[4:2]);
        ALUResult_in = alu; memRead_in = rd; memWrite_in = wr; memToReg_in = m2r;
        registerFileDataB_in = db; registerFileWrite_in = rfw; regWrite_in = rw; pcpp_in = pc;
        bus.memAck = 1'b0;
        #1;
        checks++; if (stall !== is_mem) begin errors++; $display("FAIL %s issue_stall: got %b want %b", tag, stall, is_mem); end
        @(negedge clock); #1;
        if (!is_mem) begin
            checks++;
            if ({ALUResult, regWrite, registerFileWrite, memToReg, pcpp, readData, bus.memReq} !==
                {alu, rw, rfw, m2r, pc, {DW{1'b0}}, 1'b0}) begin
                errors++;
                $display("FAIL %s passthru: got alu=%h rw=%b rfw=%h m2r=%h pc=%h rd=%h req=%b want alu=%h rw=%b rfw=%h m2r=%h pc=%h rd=0 req=0",
                         tag, ALUResult, regWrite, registerFileWrite, memToReg, pcpp, readData, bus.memReq, alu, rw, rfw, m2r, pc);
            end
            return;
        end
        checks++;
        if ({bus.memReq, bus.memWe, bus.memAddr, bus.memWdata, regWrite} !== {1'b1, wr, alu, db, 1'b0}) begin
            errors++;
            $display("FAIL %s request: got req=%b we=%b addr=%h wdata=%h rw=%b want req=1 we=%b addr=%h wdata=%h rw=0",
                     tag, bus.memReq, bus.memWe, bus.memAddr, bus.memWdata, regWrite, wr, alu, db);
        end
        rand_inputs();
        for (int i = 0; i < delay; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s busy_stall[%0d]: got %b want 1", tag, i, stall); end
            @(negedge clock); #1;
            checks++;
            if ({bus.memReq, bus.memWe, bus.memAddr, bus.memWdata, regWrite} !== {1'b1, wr, alu, db, 1'b0}) begin
                errors++;
                $display("FAIL %s busy_hold[%0d]: got req=%b we=%b addr=%h wdata=%h rw=%b", tag, i,
                         bus.memReq, bus.memWe, bus.memAddr, bus.memWdata, regWrite);
            end
            rand_inputs();
        end
        exp_rd = wr ? '0 : mem_model[idx];
        bus.memRdata = wr ? DW'($urandom) : mem_model[idx];
        bus.memAck = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s ack_stall: got %b want 0", tag, stall); end
        @(negedge clock); #1;
        bus.memAck = 1'b0;
        if (wr) mem_model[idx] = db;
        checks++;
        if ({bus.memReq, readData, ALUResult, regWrite, registerFileWrite, memToReg, pcpp} !==
            {1'b0, exp_rd, alu, rw, rfw, m2r, pc}) begin
            errors++;
            $display("FAIL %s retire: got req=%b rd=%h alu=%h rw=%b rfw=%h m2r=%h pc=%h want req=0 rd=%h alu=%h rw=%b rfw=%h m2r=%h pc=%h",
                     tag, bus.memReq, readData, ALUResult, regWrite, registerFileWrite, memToReg, pcpp,
                     exp_rd, alu, rw, rfw, m2r, pc);
        end
    endtask

    task automatic test_reset();
        rand_inputs();
        memRead_in = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.memReq, stall, memFault, regWrite, readData, ALUResult, pcpp} !== '0) begin
            errors++;
            $display("FAIL reset_initial: got req=%b stall=%b fault=%b rw=%b rd=%h alu=%h pc=%h want all 0",
                     bus.memReq, stall, memFault, regWrite, readData, ALUResult, pcpp);
        end
        @(negedge clock); #1;
        idle_inputs();
        reset = 1'b0;
        do_instr("reset_pre", 32'hCAFE_0001, 1'b0, 1'b0, 2'd2, 32'h0, 4'd9, 1'b1, 32'h0000_0104, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.memReq, stall, memFault, regWrite, readData, ALUResult, memToReg, registerFileWrite, pcpp} !== '0) begin
            errors++;
            $display("FAIL reset_midcycle: got req=%b stall=%b fault=%b rw=%b rd=%h alu=%h m2r=%h rfw=%h pc=%h want all 0",
                     bus.memReq, stall, memFault, regWrite, readData, ALUResult, memToReg, registerFileWrite, pcpp);
        end
        @(negedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_alu_passthrough();
        do_instr("alu", 32'h10, 1'b0, 1'b0, 2'd0, 32'h5555, 4'd3, 1'b1, 32'h8, 0);
        do_instr("alu2", $urandom, 1'b0, 1'b0, 2'($urandom), $urandom, RW'($urandom), 1'b0, $urandom, 0);
    endtask

    task automatic test_load();
        mem_model[0] = 32'hDEAD_BEEF;
        do_instr("load", 32'h40, 1'b1, 1'b0, 2'd1, 32'h0, 4'd5, 1'b1, 32'h20, 3);
    endtask

    task automatic test_store();
        do_instr("store", 32'h44, 1'b0, 1'b1, 2'd0, 32'h1234, 4'd0, 1'b0, 32'h24, 0);
        do_instr("store_readback", 32'h44, 1'b1, 1'b0, 2'd1, 32'h0, 4'd6, 1'b1, 32'h28, 1);
    endtask

    task automatic test_read_write_both();
        do_instr("both", 32'h48, 1'b1, 1'b1, 2'd1, 32'hA5A5_0000, 4'd7, 1'b1, 32'h2C, 2);
    endtask

    task automatic test_ack_idle();
        ALUResult_in = 32'h77; memRead_in = 1'b0; memWrite_in = 1'b0; regWrite_in = 1'b1;
        registerFileWrite_in = 4'd2; memToReg_in = 2'd0; pcpp_in = 32'h30;
        bus.memAck = 1'b1; bus.memRdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ack_idle_stall: got %b want 0", stall); end
        @(negedge clock); #1;
        checks++;
        if ({readData, bus.memReq, regWrite, ALUResult} !== {32'h0, 1'b0, 1'b1, 32'h77}) begin
            errors++;
            $display("FAIL ack_idle: got rd=%h req=%b rw=%b alu=%h want rd=0 req=0 rw=1 alu=77",
                     readData, bus.memReq, regWrite, ALUResult);
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        ALUResult_in = 32'h50; memRead_in = 1'b1; memWrite_in = 1'b0; regWrite_in = 1'b1;
        registerFileWrite_in = 4'd4; pcpp_in = 32'h40;
        @(negedge clock); #1;
        checks++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL abort_req: got %b want 1", bus.memReq); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.memReq, stall} !== 2'b00) begin
            errors++;
            $display("FAIL abort_immediate: got req=%b stall=%b want 0 0", bus.memReq, stall);
        end
        @(negedge clock); #1;
        reset = 1'b0;
        idle_inputs();
        bus.memAck = 1'b1; bus.memRdata = 32'h1111_2222;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({regWrite, readData, bus.memReq, stall} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_no_wb: got rw=%b rd=%h req=%b stall=%b want 0 0 0 0",
                     regWrite, readData, bus.memReq, stall);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [DW-1:0] addr;
            kind = $urandom_range(0, 3);
            addr = 32'h100 | (DW'($urandom_range(0, 7)) << 2);
            case (kind)
                0: do_instr("rnd_alu", $urandom, 1'b0, 1'b0, 2'($urandom), $urandom, RW'($urandom), 1'($urandom), $urandom, 0);
                1: do_instr("rnd_load", addr, 1'b1, 1'b0, 2'd1, $urandom, RW'($urandom), 1'($urandom), $urandom, $urandom_range(0, 5));
                2: do_instr("rnd_store", addr, 1'b0, 1'b1, 2'($urandom), $urandom, RW'($urandom), 1'($urandom), $urandom, $urandom_range(0, 5));
                default: do_instr("rnd_both", addr, 1'b1, 1'b1, 2'($urandom), $urandom, RW'($urandom), 1'($urandom), $urandom, $urandom_range(0, 5));
            endcase
        end
        idle_inputs();
        checks++; if (memFault !== 1'b0) begin errors++; $display("FAIL no_fault: got %b want 0", memFault); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        ALUResult_in = 32'h60; memRead_in = 1'b1; memWrite_in = 1'b0; regWrite_in = 1'b1;
        registerFileWrite_in = 4'd8; memToReg_in = 2'd1; pcpp_in = 32'h50;
        @(negedge clock); #1;
        rand_inputs();
        for (int i = 0; i < 15; i++) begin
            checks++;
            if ({stall, memFault} !== 2'b10) begin
                errors++;
                $display("FAIL tmo_wait[%0d]: got stall=%b fault=%b want 1 0", i, stall, memFault);
            end
            @(negedge clock); #1;
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tmo_stall: got %b want 0", stall); end
        @(negedge clock); #1;
        checks++;
        if ({memFault, readData, bus.memReq, regWrite, ALUResult} !== {1'b1, 32'h0, 1'b0, 1'b1, 32'h60}) begin
            errors++;
            $display("FAIL tmo_abort: got fault=%b rd=%h req=%b rw=%b alu=%h want 1 0 0 1 60",
                     memFault, readData, bus.memReq, regWrite, ALUResult);
        end
        do_instr("tmo_after", 32'h99, 1'b0, 1'b0, 2'd0, 32'h0, 4'd1, 1'b1, 32'h54, 0);
        checks++; if (memFault !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", memFault); end
        reset = 1'b1;
        #1;
        checks++; if (memFault !== 1'b0) begin errors++; $display("FAIL tmo_reset: got %b want 0", memFault); end
        @(negedge clock); #1;
        reset = 1'b0;
        idle_inputs();
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) mem_model[i] = $urandom;
        idle_inputs();
        reset = 1'b1;
        @(negedge clock); #1;
        test_reset();
        test_alu_passthrough();
        test_load();
        test_store();
        test_read_write_both();
        test_ack_idle();
        test_abort();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
